// File: rtl/aesl_deadlock_pkg.sv
// Shared state encodings and helpers for the AXIS deadlock monitor.
package aesl_deadlock_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_BLOCKED = 2'd2;
    localparam logic [1:0] ST_HELD    = 2'd3;

    // Field value for a tripped channel: all ones except the channel's own bit.
    function automatic logic [31:0] info_field(input int idx, input int n);
        logic [31:0] mask;
        mask = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
        return ~(32'd1 << idx) & mask;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/aesl_deadlock_chan_persist.sv
// Saturating persistence counter for one AXIS block signal; exposes next-cycle trip/busy.
module aesl_deadlock_chan_persist
    import aesl_deadlock_pkg::*;
#(
    parameter int THRESH = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic sig,
    output logic trip_d,
    output logic busy_d
);

    localparam int CW = (clog2(THRESH + 1) < 1) ? 1 : clog2(THRESH + 1);
    localparam logic [CW-1:0] LIM = CW'(THRESH);

    logic [CW-1:0] cnt_q, cnt_d;

    // Any low cycle restarts persistence from zero.
    always_comb begin
        cnt_d = '0;
        if (!clear && sig) begin
            cnt_d = (cnt_q == LIM) ? cnt_q : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign trip_d = (cnt_d == LIM);
    assign busy_d = (cnt_d != '0);

endmodule

// File: rtl/aesl_deadlock_axis_monitor.sv
// AXIS deadlock monitor: per-channel persistence, report FSM, info/first-channel/duration registers.
module aesl_deadlock_axis_monitor
    import aesl_deadlock_pkg::*;
#(
    parameter int NUM_AXIS = 3,
    parameter int NUM_INST = 1,
    parameter int THRESH   = 1,
    parameter int CNT_W    = 16,
    parameter int STICKY   = 0
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [NUM_AXIS-1:0]               axis_block_sigs,
    input  logic [NUM_INST-1:0]               inst_idle_sigs,
    input  logic [NUM_INST-1:0]               inst_block_sigs,
    input  logic                              clear,
    output logic [NUM_AXIS*NUM_AXIS-1:0]      axis_block_info,
    output logic                              block,
    output logic [$clog2(NUM_AXIS+1)-1:0]     first_chan,
    output logic [CNT_W-1:0]                  block_cycles,
    output logic                              all_idle
);

    localparam int FC_W = $clog2(NUM_AXIS + 1);
    localparam logic [CNT_W-1:0] CYC_MAX = '1;

    logic [NUM_AXIS-1:0] trip_d, busy_d;
    logic                inst_trip_d, any_trip, any_busy, entering, in_blk_d;

    logic [1:0]                     state_q, state_d;
    logic [NUM_AXIS-1:0]            acc_q, acc_d, shown;
    logic [NUM_AXIS*NUM_AXIS-1:0]   info_q, info_d;
    logic [FC_W-1:0]                first_q, first_d;
    logic [CNT_W-1:0]               cyc_q, cyc_d;
    logic                           all_idle_q, all_idle_d;
    logic [31:0]                    fld;
    int                             low;

    for (genvar i = 0; i < NUM_AXIS; i++) begin : g_chan
        aesl_deadlock_chan_persist #(.THRESH(THRESH)) u_chan (
            .clock   (clock),
            .reset_n (reset_n),
            .clear   (clear),
            .sig     (axis_block_sigs[i]),
            .trip_d  (trip_d[i]),
            .busy_d  (busy_d[i])
        );
    end

    // The FSM steps on the counters' next values so it lands in the same cycle they do.
    assign inst_trip_d = |inst_block_sigs && !clear;
    assign any_trip    = (|trip_d) || inst_trip_d;
    assign any_busy    = |busy_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_PENDING: begin
                if (any_trip)      state_d = ST_BLOCKED;
                else if (any_busy) state_d = ST_PENDING;
                else               state_d = ST_IDLE;
            end
            ST_BLOCKED: begin
                if (!any_trip) begin
                    if (STICKY != 0)   state_d = ST_HELD;
                    else if (any_busy) state_d = ST_PENDING;
                    else               state_d = ST_IDLE;
                end
            end
            default: state_d = state_q;
        endcase
        if (clear) state_d = ST_IDLE;

        in_blk_d = (state_d == ST_BLOCKED) || (state_d == ST_HELD);
        entering = (state_d == ST_BLOCKED) &&
                   (state_q != ST_BLOCKED) && (state_q != ST_HELD);

        low = NUM_AXIS;
        for (int i = NUM_AXIS - 1; i >= 0; i--) begin
            if (trip_d[i]) low = i;
        end

        acc_d   = '0;
        info_d  = '0;
        first_d = '0;
        cyc_d   = '0;
        shown   = '0;
        fld     = '0;
        if (in_blk_d) begin
            acc_d   = entering ? trip_d : (acc_q | trip_d);
            first_d = entering ? FC_W'(low) : first_q;
            cyc_d   = entering ? CNT_W'(1) :
                      ((cyc_q == CYC_MAX) ? cyc_q : cyc_q + CNT_W'(1));
            // HELD shows everything seen since the block started, not just the live pattern.
            shown   = (state_d == ST_HELD) ? acc_d : trip_d;
            for (int i = 0; i < NUM_AXIS; i++) begin
                if (shown[i]) begin
                    fld = info_field(i, NUM_AXIS);
                    info_d[i*NUM_AXIS +: NUM_AXIS] = fld[NUM_AXIS-1:0];
                end
            end
        end

        all_idle_d = clear ? 1'b0 : &inst_idle_sigs;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            info_q     <= '0;
            first_q    <= '0;
            cyc_q      <= '0;
            all_idle_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            info_q     <= info_d;
            first_q    <= first_d;
            cyc_q      <= cyc_d;
            all_idle_q <= all_idle_d;
        end
    end

    assign block           = (state_q == ST_BLOCKED) || (state_q == ST_HELD);
    assign axis_block_info = info_q;
    assign first_chan      = first_q;
    assign block_cycles    = cyc_q;
    assign all_idle        = all_idle_q;

endmodule
